sync_fifo_ctrl: RTL

Pointer and flag controller that sequences the single-port-write / async-read FIFO memory (sync_fifo_mem) in the synchronous FIFO.
- Accepts push/pop requests from the FIFO wrapper.
- Drives the memory write enable, write address and read address.
- Maintains occupancy and the full/empty/almost flags, plus sticky overflow/underflow error flags.
- Read data is combinational from memory at rd_addr, so the head word is visible on rd_data whenever empty=0 (first-word-fall-through).

---
 rtl/sync_fifo_ctrl_pkg.sv | 27 ++
 rtl/sync_fifo_ctrl_if.sv | 34 +++
 rtl/sync_fifo_ptr.sv | 49 ++++
 rtl/sync_fifo_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants and helpers for the synchronous FIFO pointer/flag controller.
package sync_fifo_ctrl_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_AE_LEVEL   = 2;

  // What the occupancy register does on a given edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_INC  = 2'b01,
    CNT_DEC  = 2'b10
  } cnt_op_e;

  // An accepted push and an accepted pop on the same edge cancel out.
  function automatic cnt_op_e cnt_op_f(input logic wr_ok, input logic rd_ok);
    cnt_op_e op;
    op = CNT_HOLD;
    if (wr_ok && !rd_ok) begin
      op = CNT_INC;
    end else if (rd_ok && !wr_ok) begin
      op = CNT_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Request/flag bundle between the FIFO wrapper (master) and the controller (slave).
interface sync_fifo_ctrl_if
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(DEFAULT_FIFO_DEPTH)
) ();

  logic                  wr_req;
  logic                  rd_req;
  logic                  err_clr;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_req, rd_req, err_clr,
    input  mem_wr_en, mem_wr_addr, mem_rd_addr, full, empty,
           almost_full, almost_empty, data_count, overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req, err_clr,
    output mem_wr_en, mem_wr_addr, mem_rd_addr, full, empty,
           almost_full, almost_empty, data_count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ptr.sv
// Wrapping FIFO pointer with a phase bit that toggles each time it wraps,
// so equal pointers can be told apart as empty (same phase) or full.
module sync_fifo_ptr
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  phase
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FIFO_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  phase_q, phase_d;

  // Advance by one, wrapping at FIFO_DEPTH-1 so non-power-of-two depths never reach unused addresses.
  always_comb begin
    ptr_d   = ptr_q;
    phase_d = phase_q;
    if (inc) begin
      if (ptr_q == LAST) begin
        ptr_d   = '0;
        phase_d = ~phase_q;
      end else begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Pointer and phase state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
    end
  end

  assign ptr   = ptr_q;
  assign phase = phase_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and flag controller for the first-word-fall-through
// synchronous FIFO. Flags come from registers only, so requests never
// reach them combinationally.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
  input logic             clk,
  input logic             reset_n,
  sync_fifo_ctrl_if.slave bus
);

  localparam int               CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic                  wr_ok, rd_ok;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_phase, rd_phase;
  cnt_op_e               cnt_op;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [CNT_W-1:0]      ptr_count;

  assign wr_ok = bus.wr_req & ~full_q;
  assign rd_ok = bus.rd_req & ~empty_q;

  sync_fifo_ptr #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (wr_ok),
    .ptr     (wr_ptr),
    .phase   (wr_phase)
  );

  sync_fifo_ptr #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (rd_ok),
    .ptr     (rd_ptr),
    .phase   (rd_phase)
  );

  // Next occupancy and the flags derived from it; errors are sticky and a new error beats err_clr.
  always_comb begin
    cnt_op  = cnt_op_f(wr_ok, rd_ok);
    count_d = count_q;
    unique case (cnt_op)
      CNT_INC: count_d = count_q + CNT_W'(1);
      CNT_DEC: count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
    ovf_d    = (bus.wr_req & full_q)  | (ovf_q & ~bus.err_clr);
    udf_d    = (bus.rd_req & empty_q) | (udf_q & ~bus.err_clr);
  end

  // Occupancy, flag and error registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AF_LEVEL <= 0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Occupancy implied by the {phase,ptr} pair, used only to cross-check the count register.
  always_comb begin
    ptr_count = '0;
    if (wr_phase == rd_phase) begin
      ptr_count = CNT_W'(wr_ptr) - CNT_W'(rd_ptr);
    end else begin
      ptr_count = DEPTH_C - CNT_W'(rd_ptr) + CNT_W'(wr_ptr);
    end
  end

  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!reset_n) count_q == ptr_count);

  assign bus.mem_wr_en    = wr_ok;
  assign bus.mem_wr_addr  = wr_ptr;
  assign bus.mem_rd_addr  = rd_ptr;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.data_count   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
